// File: rtl/iq_fifo_wr_arbiter_if.sv
// Port bundle for iq_fifo_wr_arbiter: two sample streams in, one tagged FIFO write port out.
interface iq_fifo_wr_arbiter_if #(parameter int DATA_WIDTH = 16);
    logic                    en_i;
    logic                    ch0_valid_i;
    logic [2*DATA_WIDTH-1:0] ch0_data_i;
    logic                    ch1_valid_i;
    logic [2*DATA_WIDTH-1:0] ch1_data_i;
    logic                    fifo_full_i;
    logic                    fifo_wr_en_o;
    logic [2*DATA_WIDTH-1:0] fifo_wr_data_o;
    logic                    busy_o;
    logic                    overflow_o;
    logic [15:0]             ch0_drops_o;
    logic [15:0]             ch1_drops_o;

    modport master (
        output en_i, ch0_valid_i, ch0_data_i, ch1_valid_i, ch1_data_i, fifo_full_i,
        input  fifo_wr_en_o, fifo_wr_data_o, busy_o, overflow_o, ch0_drops_o, ch1_drops_o
    );
    modport slave (
        input  en_i, ch0_valid_i, ch0_data_i, ch1_valid_i, ch1_data_i, fifo_full_i,
        output fifo_wr_en_o, fifo_wr_data_o, busy_o, overflow_o, ch0_drops_o, ch1_drops_o
    );
endinterface

// File: rtl/iq_fifo_wr_arbiter.sv
// Two-channel I/Q merge into one FIFO write port: 2-entry buffers, round-robin, channel tag in MSB.
// Optional per-channel saturating drop counters when ARB_DROP_CNT_EN is defined.
module iq_fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    iq_fifo_wr_arbiter_if.slave bus
);
    localparam int W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [1:0][1:0][W-1:0]  buf_q, buf_d;   // [channel][slot], slot 0 is head
    logic [1:0][1:0]         cnt_q, cnt_d;
    logic                    last_ch_q, last_ch_d;
    logic                    wr_en_q, wr_en_d;
    logic [W-1:0]            wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;

    logic [1:0]              valid;
    logic [1:0][W-1:0]       data;
    logic [1:0]              pop;
    logic [1:0]              drop;
    logic                    sel;
    logic                    clr;

    assign valid = {bus.ch1_valid_i, bus.ch0_valid_i};
    assign data  = {bus.ch1_data_i,  bus.ch0_data_i};

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        last_ch_d = last_ch_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        pop       = '0;
        drop      = '0;
        clr       = 1'b0;
        sel       = last_ch_q;

        // Arbitrate on registered occupancy so a pop never depends on this cycle's push.
        if (!bus.fifo_full_i) begin
            if (cnt_q[0] != 2'd0 && cnt_q[1] != 2'd0) sel = ~last_ch_q;
            else                                      sel = (cnt_q[0] == 2'd0);
            pop[sel] = (cnt_q[sel] != 2'd0);
        end
        if (|pop) begin
            wr_en_d   = 1'b1;
            wr_data_d = {sel, buf_q[sel][0][W-2:0]};
            last_ch_d = sel;
        end

        for (int c = 0; c < 2; c++) begin
            if (pop[c]) begin
                buf_d[c][0] = buf_q[c][1];
                cnt_d[c]    = cnt_q[c] - 2'd1;
            end
            // Post-pop occupancy decides acceptance, so a full buffer popped this edge still takes a push.
            if (state_q == RUN && valid[c]) begin
                if (cnt_d[c] < 2'd2) begin
                    buf_d[c][cnt_d[c][0]] = data[c];
                    cnt_d[c]              = cnt_d[c] + 2'd1;
                end else begin
                    drop[c] = 1'b1;
                end
            end
        end
        ovf_d = ovf_q | (|drop);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en_i) begin
                    state_d = RUN;
                    ovf_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
            RUN:     if (!bus.en_i) state_d = DRAIN;
            DRAIN:   if (cnt_q[0] == 2'd0 && cnt_q[1] == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            last_ch_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            last_ch_q <= last_ch_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.fifo_wr_en_o   = wr_en_q;
    assign bus.fifo_wr_data_o = wr_data_q;
    assign bus.busy_o         = busy_q;
    assign bus.overflow_o     = ovf_q;

`ifdef ARB_DROP_CNT_EN
    logic [1:0][15:0] drops_q, drops_d;

    always_comb begin
        drops_d = drops_q;
        for (int c = 0; c < 2; c++) begin
            if (clr)                                   drops_d[c] = 16'd0;
            else if (drop[c] && drops_q[c] != 16'hFFFF) drops_d[c] = drops_q[c] + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drops_q <= '0;
        else       drops_q <= drops_d;
    end

    assign bus.ch0_drops_o = drops_q[0];
    assign bus.ch1_drops_o = drops_q[1];
`else
    assign bus.ch0_drops_o = 16'd0;
    assign bus.ch1_drops_o = 16'd0;
`endif

endmodule

// File: tb/tb_iq_fifo_wr_arbiter.sv
// Directed, table-driven check of iq_fifo_wr_arbiter: latency, round-robin, full stall, drain, async reset.
module tb_iq_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    iq_fifo_wr_arbiter_if #(.DATA_WIDTH(16)) bus ();
    iq_fifo_wr_arbiter #(.DATA_WIDTH(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic        en, v0, v1, full;
        logic [31:0] d0, d1;
        logic        ewr, ebusy, eovf;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic v0, logic [31:0] d0, logic v1, logic [31:0] d1,
                                logic full, logic ewr, logic [31:0] edata, logic ebusy, logic eovf);
        vec_t v;
        v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.full = full;
        v.ewr = ewr; v.edata = edata; v.ebusy = ebusy; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.en_i        = v.en;
        bus.ch0_valid_i = v.v0;
        bus.ch0_data_i  = v.d0;
        bus.ch1_valid_i = v.v1;
        bus.ch1_data_i  = v.d1;
        bus.fifo_full_i = v.full;
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            chk($sformatf("%s[%0d].wr_en", tag, i - lo), {31'd0, bus.fifo_wr_en_o}, {31'd0, vecs[i].ewr});
            if (vecs[i].ewr) chk($sformatf("%s[%0d].data", tag, i - lo), bus.fifo_wr_data_o, vecs[i].edata);
            chk($sformatf("%s[%0d].busy", tag, i - lo), {31'd0, bus.busy_o}, {31'd0, vecs[i].ebusy});
            chk($sformatf("%s[%0d].ovf", tag, i - lo), {31'd0, bus.overflow_o}, {31'd0, vecs[i].eovf});
        end
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int a_lo, b_lo, b_mid, b_hi, c_lo, c_hi, d_lo, d_hi, e_lo, e_hi, f_lo, f_hi;
        logic [15:0] exp_d0, exp_d1;

        // A: single-sample latency
        a_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // B: both channels every cycle; ch0 MSB cleared by tag, ch1 MSB set
        b_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h80000000, 1, 32'h00000100, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h80000001, 1, 32'h00000101, 0, 1, 32'h00000000, 1, 0));
        vecs.push_back(mk(1, 1, 32'h80000002, 1, 32'h00000102, 0, 1, 32'h80000100, 1, 0));
        vecs.push_back(mk(1, 1, 32'h80000003, 1, 32'h00000103, 0, 1, 32'h00000001, 1, 1));
        vecs.push_back(mk(1, 1, 32'h80000004, 1, 32'h00000104, 0, 1, 32'h80000101, 1, 1));
        vecs.push_back(mk(1, 1, 32'h80000005, 1, 32'h00000105, 0, 1, 32'h00000002, 1, 1));
        vecs.push_back(mk(1, 1, 32'h80000006, 1, 32'h00000106, 0, 1, 32'h80000102, 1, 1));
        vecs.push_back(mk(1, 1, 32'h80000007, 1, 32'h00000107, 0, 1, 32'h00000003, 1, 1));
        vecs.push_back(mk(1, 1, 32'h80000008, 1, 32'h00000108, 0, 1, 32'h80000104, 1, 1));
        vecs.push_back(mk(1, 1, 32'h80000009, 1, 32'h00000109, 0, 1, 32'h00000005, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h80000106, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h00000007, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h80000108, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h00000009, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        b_mid = vecs.size();
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        b_hi = vecs.size();
        // C: FIFO full for 4 cycles while ch1 strobes
        c_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h70000000, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h70000001, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h70000002, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 32'h70000003, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'hF0000000, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'hF0000001, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        c_hi = vecs.size();
        // D: push into full ch0 buffer on the same edge it pops
        d_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h000000D0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h000000D1, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h000000D2, 0, 0, 0, 1, 32'h000000D0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h000000D1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h000000D2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        d_hi = vecs.size();
        // E: drain with one word per channel; inputs and en during DRAIN ignored
        e_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h000000E0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h000000E1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h000000E0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h000000E2, 1, 32'h000000E3, 0, 1, 32'h800000E1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e_hi = vecs.size();
        // F: words buffered before async reset; nothing must emerge afterwards
        f_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h000000F0, 1, 32'h000000F1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h000000F0, 1, 0));
        f_hi = vecs.size();

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wr_en", {31'd0, bus.fifo_wr_en_o}, 32'd0);
        chk("rst.data",  bus.fifo_wr_data_o, 32'd0);
        chk("rst.busy",  {31'd0, bus.busy_o}, 32'd0);
        chk("rst.ovf",   {31'd0, bus.overflow_o}, 32'd0);
        chk("rst.drops", {bus.ch1_drops_o, bus.ch0_drops_o}, 32'd0);
        rst = 1'b0;

        run_vecs(a_lo, b_lo, "single");

        do_reset();
        run_vecs(b_lo, b_mid, "rr");
`ifdef ARB_DROP_CNT_EN
        exp_d0 = 16'd3; exp_d1 = 16'd4;
`else
        exp_d0 = 16'd0; exp_d1 = 16'd0;
`endif
        chk("rr.ch0_drops", {16'd0, bus.ch0_drops_o}, {16'd0, exp_d0});
        chk("rr.ch1_drops", {16'd0, bus.ch1_drops_o}, {16'd0, exp_d1});
        run_vecs(b_mid, b_hi, "restart");
        chk("restart.drops", {bus.ch1_drops_o, bus.ch0_drops_o}, 32'd0);

        do_reset();
        run_vecs(c_lo, c_hi, "full");
`ifdef ARB_DROP_CNT_EN
        exp_d1 = 16'd2;
`else
        exp_d1 = 16'd0;
`endif
        chk("full.ch1_drops", {16'd0, bus.ch1_drops_o}, {16'd0, exp_d1});
        chk("full.ch0_drops", {16'd0, bus.ch0_drops_o}, 32'd0);

        do_reset();
        run_vecs(d_lo, d_hi, "pushpop");

        do_reset();
        run_vecs(e_lo, e_hi, "drain");

        do_reset();
        run_vecs(f_lo, f_hi, "arst");
        #2 rst = 1'b1;
        #1;
        chk("arst.wr_en", {31'd0, bus.fifo_wr_en_o}, 32'd0);
        chk("arst.data",  bus.fifo_wr_data_o, 32'd0);
        chk("arst.busy",  {31'd0, bus.busy_o}, 32'd0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("arst.post[%0d].wr_en", k), {31'd0, bus.fifo_wr_en_o}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/iq_fifo_wr_arbiter.md
# iq_fifo_wr_arbiter

Merges two independent I/Q sample streams (ch0 and ch1 radio receive paths) into the single write port of the receive-side dual-clock I/Q FIFO. Each channel gets a 2-entry holding buffer; a round-robin arbiter moves one word per cycle into the FIFO, tagging each word with its channel so the host can de-interleave. It runs entirely in the FIFO's write-clock domain and owns start/stop sequencing (capture, drain, idle) of the receive path.

## Interface
- DATA_WIDTH, 16, width of one I or Q sample; one FIFO word = 2*DATA_WIDTH bits
- clk_i  in  1  write-side clock (same clock as FIFO wr_clk_i)
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- en_i  in  1  capture enable; level
- ch0_valid_i  in  1  ch0 sample strobe, one word per high cycle, no backpressure
- ch0_data_i  in  2*DATA_WIDTH  ch0 word {I,Q}
- ch1_valid_i  in  1  ch1 sample strobe
- ch1_data_i  in  2*DATA_WIDTH  ch1 word {I,Q}
- fifo_full_i  in  1  FIFO full flag (write domain)
- fifo_wr_en_o  out  1  FIFO write strobe, registered
- fifo_wr_data_o  out  2*DATA_WIDTH  tagged word, registered
- busy_o  out  1  high in RUN or DRAIN
- overflow_o  out  1  sticky: a sample was dropped since last capture start
- ch0_drops_o  out  16  ch0 dropped-sample count (see Configuration)
- ch1_drops_o  out  16  ch1 dropped-sample count

## Operation
- States: IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE: inputs ignored, buffers empty, no writes. en_i=1 -> RUN; on that transition clear overflow_o and drop counters.
- RUN: valid samples pushed into own channel buffer; arbiter writes. en_i=0 -> DRAIN.
- DRAIN: inputs ignored; arbiter keeps writing until both buffers empty -> IDLE. en_i=1 during DRAIN is ignored until IDLE reached (then RUN next cycle).
- Buffer push: accepted if occupancy <2, or occupancy==2 and same edge pops that channel. Otherwise sample dropped, overflow_o set, channel drop count +1.
- Arbitration per edge, only if fifo_full_i==0: candidates = non-empty buffers; one candidate -> it; both -> channel != last_ch. last_ch resets to 1 (ch0 wins first tie). last_ch updates only on an actual write.
- Tagging: fifo_wr_data_o = {ch, word[2*DATA_WIDTH-2:0]}; MSB of I replaced by channel index (0/1).
- Order within a channel preserved (buffer is FIFO order).

## Timing
- Reset values: fifo_wr_en_o=0, fifo_wr_data_o=0, busy_o=0, overflow_o=0, drop counts=0, last_ch=1, buffers empty.
- Latency: sample valid in cycle t (buffer empty, FIFO not full, no contention) -> fifo_wr_en_o high in cycle t+2 with that word.
- Throughput: one FIFO write per cycle max; fifo_wr_en_o high only one cycle per word.
- fifo_full_i high at an edge: no write issued; buffers hold; pushes continue (drops possible).
- Simultaneous push and pop of the same channel at a full buffer: both happen, no drop.
- busy_o registered, tracks state (high in RUN/DRAIN).
- Async reset mid-RUN/DRAIN: immediately IDLE, buffered words discarded, fifo_wr_en_o=0 without waiting for clock.

## Configuration
- ARB_DROP_CNT_EN defined: ch0_drops_o/ch1_drops_o are 16-bit counters, saturate at 0xFFFF, cleared at IDLE->RUN and reset.
- Undefined: counters not built; ch0_drops_o/ch1_drops_o tied 0. overflow_o behaves identically in both builds.

## Test plan
- Single sample: en_i=1, ch0 word 0x12345678 at cycle t -> fifo_wr_en_o at t+2, data 0x12345678 (MSB 0), busy_o=1.
- Both channels valid every cycle for 10 cycles, fifo_full_i=0 -> writes alternate ch0,ch1 starting ch0, tag MSBs 0,1,0,1...; ch words in order; drops accrue once buffers fill (one channel's rate exceeds half bandwidth), overflow_o=1.
- fifo_full_i held high 4 cycles while ch1 strobes every cycle -> no writes, 2 words buffered, 2 dropped; ch1_drops_o=2 with ARB_DROP_CNT_EN, 0 without; after release first 2 buffered words written in order.
- ch0 buffer full, ch0 valid on same edge it is popped -> no drop, overflow_o stays 0.
- en_i falls with 2 words buffered -> DRAIN, both written, then IDLE, busy_o=0; samples during DRAIN not written.
- rst_i asserted mid-RUN with buffers non-empty -> outputs to reset values asynchronously; after release no stale words written.
